// File: rtl/chain_score_collector.sv
// Anchor chaining score collector: keeps a window of recent anchors, issues predecessor
// pairs to an external scoring pipeline and reduces the returned scores to a best chain score.
module chain_score_collector #(
  parameter int MAX_PRED  = 64,
  parameter int SCORE_LAT = 8,
  parameter int IDXW      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chain_clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_x,
  input  logic [31:0]            in_y,
  input  logic [31:0]            cfg_W,
  input  logic [31:0]            cfg_W_avg,
  output logic [31:0]            sc_riX,
  output logic [31:0]            sc_riY,
  output logic [31:0]            sc_qiX,
  output logic [31:0]            sc_qiY,
  output logic [31:0]            sc_W,
  output logic [31:0]            sc_W_avg,
  input  logic signed [31:0]     sc_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [31:0]     out_f,
  output logic [IDXW-1:0]        out_p,
  output logic [IDXW-1:0]        out_idx
);

  localparam int PW = $clog2(MAX_PRED);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(SCORE_LAT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FINAL, OUT} state_t;
  state_t state, state_nxt;

  logic                   rdy_en;
  logic                   pend_clear;
  logic                   accept;
  logic                   pair_ok;
  logic                   tag_hit;
  logic [CW-1:0]          count;
  logic [CW-1:0]          n_rem;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [IDXW-1:0]        anc_idx;
  logic [DW-1:0]          drain_cnt;

  logic [31:0]            cur_x;
  logic [31:0]            cur_y;
  logic [31:0]            cfg_w_q;
  logic [31:0]            cfg_wavg_q;
  logic signed [31:0]     best;
  logic signed [31:0]     cand;
  logic [IDXW-1:0]        best_p;

  logic [31:0]            hist_x   [MAX_PRED];
  logic [31:0]            hist_y   [MAX_PRED];
  logic signed [31:0]     hist_f   [MAX_PRED];
  logic [IDXW-1:0]        hist_idx [MAX_PRED];

  logic [SCORE_LAT-1:0]   tag_vld;
  logic signed [31:0]     tag_f [SCORE_LAT];
  logic [IDXW-1:0]        tag_j [SCORE_LAT];

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CW'(MAX_PRED)) ? c : c + CW'(1);
  endfunction

  // A predecessor only chains if it lies strictly below-left of the current anchor.
  assign pair_ok = (hist_x[rd_ptr] < cur_x) && (hist_y[rd_ptr] < cur_y);
  assign tag_hit = tag_vld[SCORE_LAT-1] && (state == ISSUE || state == DRAIN);
  assign cand    = tag_f[SCORE_LAT-1] + sc_result;
  assign accept  = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rdy_en & ~chain_clear;
        if (in_valid && rdy_en && !chain_clear)
          state_nxt = (count != '0) ? ISSUE : FINAL;
      end
      ISSUE:   if (n_rem == CW'(1)) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DW'(SCORE_LAT - 1)) state_nxt = FINAL;
      FINAL:   state_nxt = OUT;
      OUT:     if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en     <= 1'b0;
      pend_clear <= 1'b0;
      count      <= '0;
      n_rem      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      anc_idx    <= '0;
      drain_cnt  <= '0;
      tag_vld    <= '0;
      sc_riX     <= '0;
      sc_riY     <= '0;
      sc_qiX     <= '0;
      sc_qiY     <= '0;
      sc_W       <= '0;
      sc_W_avg   <= '0;
      out_valid  <= 1'b0;
      out_f      <= '0;
      out_p      <= '1;
      out_idx    <= '0;
    end else begin
      rdy_en  <= 1'b1;
      tag_vld <= {tag_vld[SCORE_LAT-2:0], (state == ISSUE) && pair_ok};
      if (chain_clear && state != IDLE) pend_clear <= 1'b1;
      case (state)
        IDLE: begin
          if (chain_clear) begin
            count   <= '0;
            anc_idx <= '0;
          end
          if (accept) begin
            n_rem     <= count;
            rd_ptr    <= wr_ptr - PW'(1);
            drain_cnt <= '0;
          end
        end
        ISSUE: begin
          sc_riX   <= cur_x;
          sc_riY   <= hist_x[rd_ptr];
          sc_qiX   <= cur_y;
          sc_qiY   <= hist_y[rd_ptr];
          sc_W     <= cfg_w_q;
          sc_W_avg <= cfg_wavg_q;
          n_rem    <= n_rem - CW'(1);
          rd_ptr   <= rd_ptr - PW'(1);
        end
        DRAIN: drain_cnt <= drain_cnt + DW'(1);
        FINAL: begin
          count   <= sat_inc(count);
          wr_ptr  <= wr_ptr + PW'(1);
          anc_idx <= anc_idx + IDXW'(1);
          out_f   <= best;
          out_p   <= best_p;
          out_idx <= anc_idx;
        end
        OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            // A clear seen while busy takes effect here, before the next accept.
            if (pend_clear || chain_clear) begin
              count      <= '0;
              anc_idx    <= '0;
              pend_clear <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0..p(SCORE_LAT-1): tag payload travels in step with the scoring pipeline
  always_ff @(posedge clk) begin
    tag_f[0] <= hist_f[rd_ptr];
    tag_j[0] <= hist_idx[rd_ptr];
    for (int s = 1; s < SCORE_LAT; s++) begin
      tag_f[s] <= tag_f[s-1];
      tag_j[s] <= tag_j[s-1];
    end
    if (accept) begin
      cur_x      <= in_x;
      cur_y      <= in_y;
      cfg_w_q    <= cfg_W;
      cfg_wavg_q <= cfg_W_avg;
      best       <= signed'(cfg_W);
      best_p     <= '1;
    end else if (tag_hit && (cand > best)) begin
      best   <= cand;
      best_p <= tag_j[SCORE_LAT-1];
    end
    if (state == FINAL) begin
      hist_x[wr_ptr]   <= cur_x;
      hist_y[wr_ptr]   <= cur_y;
      hist_f[wr_ptr]   <= best;
      hist_idx[wr_ptr] <= anc_idx;
    end
  end

endmodule

// File: tb/tb_chain_score_collector.sv
// Scoreboard bench for chain_score_collector: driver pushes expected chain results,
// an independent monitor pops and compares them as the DUT presents outputs.
module tb_chain_score_collector;

  localparam int MAX_PRED  = 64;
  localparam int SCORE_LAT = 8;
  localparam int IDXW      = 16;
  localparam logic [15:0] NONE = 16'hFFFF;

  logic clk, reset, chain_clear, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_x, in_y, cfg_W, cfg_W_avg;
  logic [31:0] sc_riX, sc_riY, sc_qiX, sc_qiY, sc_W, sc_W_avg;
  logic signed [31:0] sc_result, score, out_f;
  logic [IDXW-1:0] out_p, out_idx;

  typedef struct {
    logic [31:0] f;
    logic [15:0] p;
    logic [15:0] idx;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  chain_score_collector #(.MAX_PRED(MAX_PRED), .SCORE_LAT(SCORE_LAT), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .chain_clear(chain_clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .cfg_W(cfg_W), .cfg_W_avg(cfg_W_avg),
    .sc_riX(sc_riX), .sc_riY(sc_riY), .sc_qiX(sc_qiX), .sc_qiY(sc_qiY),
    .sc_W(sc_W), .sc_W_avg(sc_W_avg), .sc_result(sc_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_p(out_p), .out_idx(out_idx)
  );

  // Scoring pipeline model: every pair scores the same constant.
  assign sc_result = score;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor
  initial begin
    bit seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            check("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
          end
          check(out_ready ? "out_f" : "stall_out_f", out_f, sbq[0].f);
          check(out_ready ? "out_p" : "stall_out_p", 32'(out_p), 32'(sbq[0].p));
          check(out_ready ? "out_idx" : "stall_out_idx", 32'(out_idx), 32'(sbq[0].idx));
          if (!out_ready) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
          end else begin
            void'(sbq.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ef,
                      input logic [15:0] ep, input logic [15:0] ei, input int en);
    int t = 0;
    @(posedge clk); #1;
    while (!in_ready && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_x = x;
      in_y = y;
      in_valid = 1'b1;
      sbq.push_back('{ef, ep, ei, (en > 0) ? en + SCORE_LAT + 2 : 2, cyc + 1});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while ((sbq.size() != 0 || !in_ready) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) check("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    int t;
    reset = 1'b1; chain_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_x = '0; in_y = '0; cfg_W = 32'd15; cfg_W_avg = 32'd50; score = 32'sd5;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_f", out_f, 32'd0);
    check("rst_out_p", 32'(out_p), 32'(NONE));
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_sc_riX", sc_riX, 32'd0);
    check("rst_sc_qiY", sc_qiY, 32'd0);
    check("rst_sc_W", sc_W, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // Basic chaining, one rejected predecessor on the third anchor
    send(32'd10, 32'd10, 32'd15, NONE, 16'd0, 0);
    send(32'd20, 32'd20, 32'd20, 16'd0, 16'd1, 1);
    send(32'd15, 32'd30, 32'd20, 16'd0, 16'd2, 2);
    wait_done();
    check("sc_riX_hold", sc_riX, 32'd15);
    check("sc_riY_hold", sc_riY, 32'd10);
    check("sc_qiX_hold", sc_qiX, 32'd30);
    check("sc_qiY_hold", sc_qiY, 32'd10);
    check("sc_W_hold", sc_W, 32'd15);
    check("sc_W_avg_hold", sc_W_avg, 32'd50);

    // Clear in IDLE blocks a concurrent in_valid
    @(posedge clk); #1;
    chain_clear = 1'b1; in_valid = 1'b1; in_x = 32'd3; in_y = 32'd3;
    #1 check("ready_during_clear", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chain_clear = 1'b0; in_valid = 1'b0;

    // Negative pair scores never beat W
    score = -32'sd30;
    send(32'd1, 32'd1, 32'd15, NONE, 16'd0, 0);
    send(32'd2, 32'd2, 32'd15, NONE, 16'd1, 1);
    wait_done();

    // Tie keeps nearer predecessor; stall in OUT with a clear pulse
    score = 32'sd5;
    out_ready = 1'b0;
    send(32'd5, 32'd5, 32'd20, 16'd1, 16'd2, 2);
    t = 0;
    while (!out_valid && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!out_valid) check("stall_wait_timeout", 32'(out_valid), 32'd1);
    repeat (4) @(posedge clk);
    #1 chain_clear = 1'b1;
    @(posedge clk); #1;
    chain_clear = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    send(32'd7, 32'd7, 32'd15, NONE, 16'd0, 0);
    wait_done();

    // Window saturation over 70 monotonic anchors
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 70; k++)
      send(32'(k), 32'(k), 32'(15 + 5 * k), (k == 0) ? NONE : 16'(k - 1), 16'(k),
           (k < MAX_PRED) ? k : MAX_PRED);
    wait_done();

    // Reset mid-issue abandons the anchor and empties the window
    @(posedge clk); #1;
    in_x = 32'd1000; in_y = 32'd1000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    send(32'd9, 32'd9, 32'd15, NONE, 16'd0, 0);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
